// File: rtl/dma_request_arbiter_if.sv
// Handshake and register bus between the DMA request arbiter and its surroundings.
// "master" is the system/timing-control side; "slave" is the arbiter itself.
interface dma_request_arbiter_if;
  logic        cs;
  logic        wr;
  logic [2:0]  addr;
  logic [15:0] data_in;
  logic [3:0]  dreq;
  logic        hlda;
  logic        xfer_done;
  logic        hrq;
  logic [3:0]  dack;
  logic [1:0]  ch_sel;
  logic        busy;
  logic        tc;

  modport master (
    output cs, wr, addr, data_in, dreq, hlda, xfer_done,
    input  hrq, dack, ch_sel, busy, tc
  );

  modport slave (
    input  cs, wr, addr, data_in, dreq, hlda, xfer_done,
    output hrq, dack, ch_sel, busy, tc
  );
endinterface

// File: rtl/dma_request_arbiter.sv
// DMA request/priority stage: picks a channel from four DREQ lines, runs the HRQ/HLDA
// handshake, keeps per-channel transfer counters and pulses TC when a channel finishes.
module dma_request_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_request_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count   [NCH];
  logic [CW-1:0]    count_n [NCH];
  logic [NCH-1:0]   mask, mask_n;
  logic             rot_en, rot_en_n;
  logic [NCH-1:0]   block_en, block_en_n;
  logic [1:0]       ptr, ptr_n;
  logic             hrq_q, hrq_n;
  logic [NCH-1:0]   dack_q, dack_n;
  logic [1:0]       ch_sel_q, ch_sel_n;
  logic             busy_q, busy_n;
  logic             tc_q, tc_n;

  logic [NCH-1:0]   active;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             wr_en;
  logic             leave;

  assign active = bus.dreq & ~mask;
  assign wr_en  = bus.cs & bus.wr & ~bus.hlda;

  assign bus.hrq    = hrq_q;
  assign bus.dack   = dack_q;
  assign bus.ch_sel = ch_sel_q;
  assign bus.busy   = busy_q;
  assign bus.tc     = tc_q;

  // Priority search starts at channel 0, or at the rotation pointer when rotating.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = (rot_en ? ptr : 2'd0) + 2'(i);
      if (!found && active[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    hrq_n      = hrq_q;
    dack_n     = dack_q;
    ch_sel_n   = ch_sel_q;
    busy_n     = busy_q;
    tc_n       = 1'b0;
    mask_n     = mask;
    count_n    = count;
    rot_en_n   = rot_en;
    block_en_n = block_en;
    ptr_n      = ptr;
    leave      = 1'b0;

    if (wr_en) begin
      case (bus.addr)
        3'd0, 3'd1, 3'd2, 3'd3: count_n[bus.addr[1:0]] = CW'(bus.data_in);
        3'd4: mask_n = bus.data_in[3:0];
        3'd5: begin
          rot_en_n   = bus.data_in[0];
          block_en_n = bus.data_in[7:4];
        end
        default: ;
      endcase
    end

    case (state)
      IDLE: begin
        hrq_n  = 1'b0;
        dack_n = '0;
        busy_n = 1'b0;
        if ((|active) && !bus.hlda) begin
          state_n = REQ;
          hrq_n   = 1'b1;
        end
      end
      REQ: begin
        if (bus.hlda) begin
          if (|active) begin
            state_n  = GRANT;
            ch_sel_n = win;
            dack_n   = 4'b0001 << win;
            busy_n   = 1'b1;
          end else begin
            state_n = IDLE;
            hrq_n   = 1'b0;
          end
        end
      end
      GRANT: begin
        // A transfer landing with an hlda fall is still counted before exiting.
        if (bus.xfer_done) begin
          if (count[ch_sel_q] == '0) begin
            tc_n             = 1'b1;
            mask_n[ch_sel_q] = 1'b1;
            ptr_n            = ch_sel_q + 2'd1;
            leave            = 1'b1;
          end else begin
            count_n[ch_sel_q] = count[ch_sel_q] - CW'(1);
            if (!block_en[ch_sel_q]) begin
              ptr_n = ch_sel_q + 2'd1;
              leave = 1'b1;
            end else if (!bus.hlda) begin
              leave = 1'b1;
            end
          end
        end else if (!bus.hlda) begin
          leave = 1'b1;
        end
        if (leave) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
          dack_n  = '0;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      for (int i = 0; i < NCH; i++) count[i] <= '0;
      mask     <= '1;
      rot_en   <= 1'b0;
      block_en <= '0;
      ptr      <= '0;
      hrq_q    <= 1'b0;
      dack_q   <= '0;
      ch_sel_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      mask     <= mask_n;
      rot_en   <= rot_en_n;
      block_en <= block_en_n;
      ptr      <= ptr_n;
      hrq_q    <= hrq_n;
      dack_q   <= dack_n;
      ch_sel_q <= ch_sel_n;
      busy_q   <= busy_n;
      tc_q     <= tc_n;
    end
  end

endmodule
